vend_ctrl_param: RTL and testbench

- Parametrised successor to the single-product vending controller.
- Supports N selectable items with per-item price and per-item stock counters, saturating credit, and a timed step-wise refund.
- Takes debounced one-pulse coin, cancel, select and restock inputs (buttons or keyboard decoder).
- Drives the credit value to the seven-segment driver and availability bits to the LEDs.

---
 rtl/vend_ctrl_param.sv | 140 ++++++++++++++
 tb/tb_vend_ctrl_param.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl_param.sv
// Parametrised multi-item vending controller: saturating credit, per-item stock,
// priority-arbitrated one-pulse inputs and a timed step-wise refund.
module vend_ctrl_param #(
    parameter int                          N_ITEMS     = 4,
    parameter int                          CREDIT_W    = 8,
    parameter int                          MAX_CREDIT  = 100,
    parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES      = {8'd80, 8'd30, 8'd25, 8'd20},
    parameter int                          STOCK_W     = 4,
    parameter int                          STOCK_INIT  = 5,
    parameter int                          REFUND_STEP = 5,
    parameter int                          TICK_DIV    = 100_000_000
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               coin_5,
    input  logic                                               coin_10,
    input  logic                                               coin_50,
    input  logic                                               cancel,
    input  logic [N_ITEMS-1:0]                                 sel,
    input  logic                                               restock,
    output logic [CREDIT_W-1:0]                                credit,
    output logic [N_ITEMS-1:0]                                 avail,
    output logic [N_ITEMS-1:0]                                 stock_empty,
    output logic                                               vend_pulse,
    output logic [((N_ITEMS > 1) ? $clog2(N_ITEMS) : 1)-1:0]   vend_item,
    output logic                                               refund_pulse,
    output logic                                               coin_reject,
    output logic                                               busy
);

    localparam int IDX_W  = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {IDLE, REFUND} state_t;

    state_t              state;
    logic [STOCK_W-1:0]  stock [N_ITEMS];
    logic [TICK_W-1:0]   tick_cnt;
    logic [CREDIT_W-1:0] price [N_ITEMS];
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   coin_sum;
    logic [IDX_W-1:0]    sel_idx;
    logic                sel_any;
    logic                any_coin;
    logic                coin_dropped;

    assign busy         = (state == REFUND);
    assign any_coin     = coin_5 | coin_10 | coin_50;
    assign coin_dropped = (coin_50 & (coin_10 | coin_5)) | (coin_10 & coin_5);
    assign coin_sum     = {1'b0, credit} + coin_val;

    always_comb begin
        for (int i = 0; i < N_ITEMS; i++) begin
            price[i]       = PRICES[i*CREDIT_W +: CREDIT_W];
            stock_empty[i] = (stock[i] == '0);
            avail[i]       = (state == IDLE) && (credit >= price[i]) && (stock[i] != '0);
        end
    end

    // Highest-value coin wins; the lower ones in the same cycle are dropped.
    always_comb begin
        coin_val = '0;
        if (coin_50)      coin_val = (CREDIT_W+1)'(50);
        else if (coin_10) coin_val = (CREDIT_W+1)'(10);
        else if (coin_5)  coin_val = (CREDIT_W+1)'(5);
    end

    always_comb begin
        sel_idx = '0;
        sel_any = 1'b0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (sel[i]) begin
                sel_idx = IDX_W'(i);
                sel_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            credit       <= '0;
            tick_cnt     <= '0;
            vend_pulse   <= 1'b0;
            vend_item    <= '0;
            refund_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            for (int i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
        end else begin
            vend_pulse   <= 1'b0;
            refund_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    if (cancel) begin
                        coin_reject <= any_coin;
                        if (credit != '0) state <= REFUND;
                    end else if (any_coin) begin
                        if (credit == CREDIT_W'(MAX_CREDIT)) begin
                            coin_reject <= 1'b1;
                        end else begin
                            coin_reject <= coin_dropped;
                            if (coin_sum > (CREDIT_W+1)'(MAX_CREDIT)) credit <= CREDIT_W'(MAX_CREDIT);
                            else                                      credit <= coin_sum[CREDIT_W-1:0];
                        end
                    end else if (sel_any) begin
                        if (avail[sel_idx]) begin
                            vend_pulse     <= 1'b1;
                            vend_item      <= sel_idx;
                            credit         <= credit - price[sel_idx];
                            stock[sel_idx] <= stock[sel_idx] - STOCK_W'(1);
                            if (credit != price[sel_idx]) state <= REFUND;
                        end
                    end else if (restock) begin
                        for (int i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
                    end
                end
                REFUND: begin
                    coin_reject <= any_coin;
                    // One refund step per wrap of the tick counter; leave once credit is exhausted.
                    if (tick_cnt == TICK_W'(TICK_DIV - 1)) begin
                        tick_cnt     <= '0;
                        refund_pulse <= 1'b1;
                        if (credit <= CREDIT_W'(REFUND_STEP)) begin
                            credit <= '0;
                            state  <= IDLE;
                        end else begin
                            credit <= credit - CREDIT_W'(REFUND_STEP);
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Self-checking bench for vend_ctrl_param: an integer-level behavioural model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_vend_ctrl_param;

    localparam int          N           = 4;
    localparam int          MAX_C       = 100;
    localparam int          STOCK_INIT  = 5;
    localparam int          STEP        = 10;
    localparam int          TICKS       = 4;
    localparam logic [31:0] PRICES_TB   = {8'd80, 8'd30, 8'd25, 8'd20};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_5 = 0, coin_10 = 0, coin_50 = 0, cancel = 0, restock = 0;
    logic [3:0] sel = '0;
    logic [7:0] credit;
    logic [3:0] avail, stock_empty;
    logic       vend_pulse, refund_pulse, coin_reject, busy;
    logic [1:0] vend_item;

    int checks   = 0;
    int failures = 0;

    vend_ctrl_param #(
        .N_ITEMS(N), .CREDIT_W(8), .MAX_CREDIT(MAX_C), .PRICES(PRICES_TB),
        .STOCK_W(4), .STOCK_INIT(STOCK_INIT), .REFUND_STEP(STEP), .TICK_DIV(TICKS)
    ) dut (
        .clk(clk), .rst(rst), .coin_5(coin_5), .coin_10(coin_10), .coin_50(coin_50),
        .cancel(cancel), .sel(sel), .restock(restock), .credit(credit), .avail(avail),
        .stock_empty(stock_empty), .vend_pulse(vend_pulse), .vend_item(vend_item),
        .refund_pulse(refund_pulse), .coin_reject(coin_reject), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model state: prices read off the packed parameter by hand.
    int prices [N] = '{20, 25, 30, 80};
    int m_credit = 0;
    int m_stock [N] = '{5, 5, 5, 5};
    bit m_refund = 0;
    int m_elapsed = 0;
    bit m_vp = 0, m_rp = 0, m_cr = 0;
    int m_vi = 0;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        int val, n_coins, hi;
        if (rst) begin
            m_credit = 0; m_refund = 0; m_elapsed = 0;
            m_vp = 0; m_rp = 0; m_cr = 0; m_vi = 0;
            for (int i = 0; i < N; i++) m_stock[i] = STOCK_INIT;
        end else begin
            m_vp = 0; m_rp = 0; m_cr = 0;
            n_coins = int'(coin_5) + int'(coin_10) + int'(coin_50);
            if (!m_refund) begin
                if (cancel) begin
                    m_cr = (n_coins > 0);
                    if (m_credit > 0) begin m_refund = 1; m_elapsed = 0; end
                end else if (n_coins > 0) begin
                    val = coin_50 ? 50 : (coin_10 ? 10 : 5);
                    if (m_credit == MAX_C) m_cr = 1;
                    else begin
                        m_cr = (n_coins > 1);
                        m_credit = (m_credit + val > MAX_C) ? MAX_C : m_credit + val;
                    end
                end else if (sel != 0) begin
                    hi = 0;
                    for (int i = 0; i < N; i++) if (sel[i]) hi = i;
                    if (m_credit >= prices[hi] && m_stock[hi] > 0) begin
                        m_vp = 1; m_vi = hi;
                        m_credit -= prices[hi];
                        m_stock[hi]--;
                        if (m_credit > 0) begin m_refund = 1; m_elapsed = 0; end
                    end
                end else if (restock) begin
                    for (int i = 0; i < N; i++) m_stock[i] = STOCK_INIT;
                end
            end else begin
                m_cr = (n_coins > 0);
                m_elapsed++;
                if (m_elapsed == TICKS) begin
                    m_elapsed = 0;
                    m_rp = 1;
                    m_credit = (m_credit < STEP) ? 0 : m_credit - STEP;
                    if (m_credit == 0) m_refund = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] exp_avail, exp_empty;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                exp_avail[i] = !m_refund && (m_credit >= prices[i]) && (m_stock[i] > 0);
                exp_empty[i] = (m_stock[i] == 0);
            end
            check_output("credit", int'(credit), m_credit);
            check_output("avail", int'(avail), int'(exp_avail));
            check_output("stock_empty", int'(stock_empty), int'(exp_empty));
            check_output("vend_pulse", int'(vend_pulse), int'(m_vp));
            if (m_vp) check_output("vend_item", int'(vend_item), m_vi);
            check_output("refund_pulse", int'(refund_pulse), int'(m_rp));
            check_output("coin_reject", int'(coin_reject), int'(m_cr));
            check_output("busy", int'(busy), int'(m_refund));
        end
    end

    // Called at a falling edge: holds the pulses for one cycle, returns at the next falling edge.
    task automatic apply_stimulus(input logic c5, input logic c10, input logic c50,
                                  input logic can, input logic [3:0] s, input logic rs);
        coin_5 = c5; coin_10 = c10; coin_50 = c50; cancel = can; sel = s; restock = rs;
        @(negedge clk);
        coin_5 = 0; coin_10 = 0; coin_50 = 0; cancel = 0; sel = '0; restock = 0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (busy && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check_output("refund_done_in_budget", int'(busy), 0);
    endtask

    initial begin
        int exp_seq [3] = '{15, 5, 0};
        int n_pulses;

        repeat (2) @(negedge clk);
        #2 rst = 0;
        @(negedge clk);
        check_output("reset_credit", int'(credit), 0);
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_avail", int'(avail), 0);
        check_output("reset_stock_empty", int'(stock_empty), 0);

        // Saturation
        apply_stimulus(0, 0, 1, 0, 4'b0000, 0);
        check_output("sat_credit_1", int'(credit), 50);
        apply_stimulus(0, 0, 1, 0, 4'b0000, 0);
        check_output("sat_credit_2", int'(credit), 100);
        check_output("sat_reject_2", int'(coin_reject), 0);
        apply_stimulus(0, 1, 0, 0, 4'b0000, 0);
        check_output("sat_credit_3", int'(credit), 100);
        check_output("sat_reject_3", int'(coin_reject), 1);
        apply_stimulus(0, 0, 0, 1, 4'b0000, 0);
        wait_idle(60);

        // Vend with change: 35 in, item 2 costs 30
        apply_stimulus(0, 1, 0, 0, 4'b0000, 0);
        apply_stimulus(0, 1, 0, 0, 4'b0000, 0);
        apply_stimulus(0, 1, 0, 0, 4'b0000, 0);
        apply_stimulus(1, 0, 0, 0, 4'b0000, 0);
        check_output("change_credit_35", int'(credit), 35);
        apply_stimulus(0, 0, 0, 0, 4'b0100, 0);
        check_output("change_vend_pulse", int'(vend_pulse), 1);
        check_output("change_vend_item", int'(vend_item), 2);
        check_output("change_credit_5", int'(credit), 5);
        check_output("change_busy", int'(busy), 1);
        repeat (3) @(negedge clk);
        check_output("change_no_early_tick", int'(refund_pulse), 0);
        @(negedge clk);
        check_output("change_refund_pulse", int'(refund_pulse), 1);
        check_output("change_credit_0", int'(credit), 0);
        check_output("change_back_idle", int'(busy), 0);

        // Cancel refund from 25 in steps of 10
        apply_stimulus(0, 1, 0, 0, 4'b0000, 0);
        apply_stimulus(0, 1, 0, 0, 4'b0000, 0);
        apply_stimulus(1, 0, 0, 0, 4'b0000, 0);
        apply_stimulus(0, 0, 0, 1, 4'b0000, 0);
        apply_stimulus(1, 0, 0, 0, 4'b0000, 0);
        check_output("refund_coin_reject", int'(coin_reject), 1);
        check_output("refund_credit_kept", int'(credit), 25);
        n_pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (refund_pulse) begin
                if (n_pulses < 3) check_output("refund_step_credit", int'(credit), exp_seq[n_pulses]);
                n_pulses++;
            end
        end
        check_output("refund_pulse_count", n_pulses, 3);
        check_output("refund_done", int'(busy), 0);

        // Stock exhaustion on item 0
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(0, 1, 0, 0, 4'b0000, 0);
            apply_stimulus(0, 1, 0, 0, 4'b0000, 0);
            apply_stimulus(0, 0, 0, 0, 4'b0001, 0);
            check_output("exhaust_vend", int'(vend_pulse), 1);
        end
        check_output("exhaust_empty", int'(stock_empty), 4'b0001);
        apply_stimulus(0, 0, 1, 0, 4'b0000, 0);
        apply_stimulus(0, 0, 1, 0, 4'b0000, 0);
        check_output("exhaust_avail", int'(avail), 4'b1110);
        apply_stimulus(0, 0, 0, 0, 4'b0001, 0);
        check_output("exhaust_sel_ignored", int'(vend_pulse), 0);
        check_output("exhaust_credit", int'(credit), 100);
        apply_stimulus(0, 0, 0, 0, 4'b0000, 1);
        check_output("restock_avail", int'(avail), 4'b1111);
        apply_stimulus(0, 0, 0, 1, 4'b0000, 0);
        wait_idle(60);

        // Dropped lower coin, then coin beats select at credit 80
        apply_stimulus(1, 0, 1, 0, 4'b0000, 0);
        check_output("drop_credit", int'(credit), 50);
        check_output("drop_reject", int'(coin_reject), 1);
        for (int k = 0; k < 3; k++) apply_stimulus(0, 1, 0, 0, 4'b0000, 0);
        check_output("simul_pre_credit", int'(credit), 80);
        apply_stimulus(0, 1, 0, 0, 4'b1000, 0);
        check_output("simul_credit", int'(credit), 90);
        check_output("simul_no_vend", int'(vend_pulse), 0);
        check_output("simul_no_reject", int'(coin_reject), 0);
        apply_stimulus(0, 0, 0, 1, 4'b0000, 0);
        wait_idle(60);

        // Asynchronous reset in the middle of a refund
        apply_stimulus(0, 0, 1, 0, 4'b0000, 0);
        apply_stimulus(0, 0, 0, 0, 4'b0100, 0);
        check_output("midrst_pre_busy", int'(busy), 1);
        check_output("midrst_pre_credit", int'(credit), 20);
        #2 rst = 1;
        #1;
        check_output("midrst_credit", int'(credit), 0);
        check_output("midrst_busy", int'(busy), 0);
        check_output("midrst_avail", int'(avail), 0);
        check_output("midrst_stock_empty", int'(stock_empty), 0);
        @(negedge clk);
        #2 rst = 0;
        @(negedge clk);
        repeat (8) @(negedge clk);
        check_output("midrst_no_refund", int'(refund_pulse), 0);
        check_output("midrst_credit_after", int'(credit), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
